// File: rtl/div_pkg.sv
// Shared types and defaults for the signed-divider load/collect sequencer.
package div_pkg;

  localparam int unsigned DIV_DW         = 16;
  localparam int unsigned DIV_CYCLES_DEF = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_U,
    S_LD_L,
    S_LD_D,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } div_seq_state_t;

endpackage

// File: rtl/div_seq_loader.sv
// Sequences one operand pair onto the signeddivider databus, waits out the
// divide latency, captures the result and offers it on a valid/ready port.
module div_seq_loader
  import div_pkg::*;
#(
  parameter int unsigned DW         = DIV_DW,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  localparam int unsigned CW        = $clog2(DIV_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2*DW-1:0] op_dividend,
  input  logic [DW-1:0]   op_divisor,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_quo,
  output logic [DW-1:0]   res_rem,
  output logic            res_ovf,
  output logic [DW-1:0]   div_databus,
  output logic            div_ldu,
  output logic            div_ldl,
  output logic            div_ldd,
  output logic            div_st,
  output logic            div_ena,
  input  logic [DW-1:0]   div_quo,
  input  logic [DW-1:0]   div_rem,
  input  logic            div_v,
  output logic            busy
);

  div_seq_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic [DW-1:0]   quo_d, rem_d;
  logic            ovf_d;
  logic            op_ready_d, res_valid_d, busy_d;
  logic [DW-1:0]   databus_d;
  logic            ldu_d, ldl_d, ldd_d, st_d, ena_d;

  // Next state, then Moore outputs decoded from the next state so that the
  // registered outputs always match the registered state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quo_d       = res_quo;
    rem_d       = res_rem;
    ovf_d       = res_ovf;
    op_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    busy_d      = 1'b1;
    databus_d   = '0;
    ldu_d       = 1'b0;
    ldl_d       = 1'b0;
    ldd_d       = 1'b0;
    st_d        = 1'b0;
    ena_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          dividend_d = op_dividend;
          divisor_d  = op_divisor;
          if (op_divisor == '0) begin
            // Divide-by-zero never reaches the divider.
            quo_d   = '0;
            rem_d   = '0;
            ovf_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_LD_U;
          end
        end
      end
      S_LD_U:  state_d = S_LD_L;
      S_LD_L:  state_d = S_LD_D;
      S_LD_D:  state_d = S_START;
      S_START: begin
        cnt_d   = CW'(DIV_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CAPTURE: begin
        quo_d   = div_quo;
        rem_d   = div_rem;
        ovf_d   = div_v;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE: begin
        op_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      S_LD_U: begin
        databus_d = dividend_d[2*DW-1:DW];
        ldu_d     = 1'b1;
      end
      S_LD_L: begin
        databus_d = dividend_d[DW-1:0];
        ldl_d     = 1'b1;
      end
      S_LD_D: begin
        databus_d = divisor_d;
        ldd_d     = 1'b1;
      end
      S_START:   st_d        = 1'b1;
      S_CAPTURE: ena_d       = 1'b1;
      S_RESP:    res_valid_d = 1'b1;
      default:   busy_d      = 1'b1;
    endcase
  end

  // State, operand, result and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      res_quo     <= '0;
      res_rem     <= '0;
      res_ovf     <= 1'b0;
      op_ready    <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      div_databus <= '0;
      div_ldu     <= 1'b0;
      div_ldl     <= 1'b0;
      div_ldd     <= 1'b0;
      div_st      <= 1'b0;
      div_ena     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      res_quo     <= quo_d;
      res_rem     <= rem_d;
      res_ovf     <= ovf_d;
      op_ready    <= op_ready_d;
      res_valid   <= res_valid_d;
      busy        <= busy_d;
      div_databus <= databus_d;
      div_ldu     <= ldu_d;
      div_ldl     <= ldl_d;
      div_ldd     <= ldd_d;
      div_st      <= st_d;
      div_ena     <= ena_d;
    end
  end

endmodule

// File: tb/tb_div_seq_loader.sv
// Randomised scoreboard bench for div_seq_loader with a behavioural divider.
module tb_div_seq_loader;
  import div_pkg::*;

  localparam int unsigned DW = DIV_DW;
  localparam int unsigned DC = DIV_CYCLES_DEF;
  localparam longint QMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (DW - 1));

  logic            clk = 1'b0;
  logic            rst_n;
  logic            op_valid, op_ready;
  logic [2*DW-1:0] op_dividend;
  logic [DW-1:0]   op_divisor;
  logic            res_valid, res_ready;
  logic [DW-1:0]   res_quo, res_rem;
  logic            res_ovf;
  logic [DW-1:0]   div_databus;
  logic            div_ldu, div_ldl, div_ldd, div_st, div_ena;
  logic [DW-1:0]   div_quo, div_rem;
  logic            div_v;
  logic            busy;

  always #5 clk = ~clk;

  div_seq_loader dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_dividend(op_dividend), .op_divisor(op_divisor),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quo(res_quo), .res_rem(res_rem), .res_ovf(res_ovf),
    .div_databus(div_databus), .div_ldu(div_ldu), .div_ldl(div_ldl),
    .div_ldd(div_ldd), .div_st(div_st), .div_ena(div_ena),
    .div_quo(div_quo), .div_rem(div_rem), .div_v(div_v),
    .busy(busy)
  );

  typedef struct packed {
    logic [2*DW-1:0] dd;
    logic [DW-1:0]   dv;
    logic [DW-1:0]   quo;
    logic [DW-1:0]   rem;
    logic            ovf;
    logic            zdiv;
    int              base;
  } exp_t;

  typedef struct packed {
    int            kind;
    logic [DW-1:0] bus;
    int            rel;
  } log_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accepted = 0;
  int   retired = 0;
  int   rr_mode = 1;
  exp_t exp_q[$];
  log_t slog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: plain truncating signed division on wide integers.
  function automatic exp_t ref_model(input logic [2*DW-1:0] dd, input logic [DW-1:0] dv);
    exp_t   e;
    longint a, b, q, r;
    a = longint'($signed(dd));
    b = longint'($signed(dv));
    e = '0;
    e.dd = dd;
    e.dv = dv;
    if (b == 0) begin
      e.zdiv = 1'b1;
      e.ovf  = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      e.quo = q[DW-1:0];
      e.rem = r[DW-1:0];
      e.ovf = (q > QMAX) || (q < QMIN);
    end
    return e;
  endfunction

  // Downstream divider: outputs are only meaningful DC cycles after st and
  // while ena is high; otherwise they show the inverted answer.
  logic [DW-1:0] m_hi = '0, m_lo = '0, m_dv = '0;
  int            m_cnt = 0;
  exp_t          m_res = '0;
  logic          m_ok;

  always @(posedge clk) begin
    if (div_ldu) begin
      m_hi  <= div_databus;
      m_cnt <= 0;
    end
    if (div_ldl) m_lo <= div_databus;
    if (div_ldd) m_dv <= div_databus;
    if (div_st) begin
      m_cnt <= DC;
      m_res <= ref_model({m_hi, m_lo}, m_dv);
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign m_ok    = (m_cnt == 1) && div_ena;
  assign div_quo = m_ok ? m_res.quo : ~m_res.quo;
  assign div_rem = m_ok ? m_res.rem : ~m_res.rem;
  assign div_v   = m_ok ? m_res.ovf : ~m_res.ovf;

  // Result consumer.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       res_ready = ($urandom_range(0, 3) != 0);
        1:       res_ready = 1'b1;
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples just after each rising edge.
  initial begin
    bit            prev_rv = 1'b0;
    logic [DW-1:0] hq = '0, hr = '0;
    logic          hov = 1'b0;
    exp_t          e;
    int            rel, nexp;
    int            ekind[5];
    int            erel[5];
    logic [DW-1:0] ebus[5];
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        prev_rv = 1'b0;
        continue;
      end
      if (prev_rv && res_ready) begin
        retired++;
        check("res_valid_drop", 64'(res_valid), 64'd0);
      end
      check("op_ready", 64'(op_ready), 64'(accepted == retired));
      check("busy", 64'(busy), 64'(accepted != retired));
      check("strobe_onehot", 64'($countones({div_ldu, div_ldl, div_ldd, div_st, div_ena}) <= 1), 64'd1);

      rel = (exp_q.size() > 0) ? cyc - exp_q[0].base : -1;
      if (div_ldu) slog.push_back('{1, div_databus, rel});
      if (div_ldl) slog.push_back('{2, div_databus, rel});
      if (div_ldd) slog.push_back('{3, div_databus, rel});
      if (div_st)  slog.push_back('{4, div_databus, rel});
      if (div_ena) slog.push_back('{5, '0, rel});

      if (res_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          check("res_quo", 64'(res_quo), 64'(e.quo));
          check("res_rem", 64'(res_rem), 64'(e.rem));
          check("res_ovf", 64'(res_ovf), 64'(e.ovf));
          check("res_latency", 64'(cyc - e.base), e.zdiv ? 64'd1 : 64'(6 + DC));
          ekind = '{1, 2, 3, 4, 5};
          erel  = '{1, 2, 3, 4, 5 + DC};
          ebus  = '{e.dd[2*DW-1:DW], e.dd[DW-1:0], e.dv, '0, '0};
          nexp  = e.zdiv ? 0 : 5;
          check("strobe_count", 64'(slog.size()), 64'(nexp));
          for (int i = 0; i < slog.size() && i < nexp; i++)
            check("strobe_seq", {slog[i].kind, slog[i].bus, slog[i].rel},
                  {ekind[i], ebus[i], erel[i]});
          slog.delete();
          hq  = res_quo;
          hr  = res_rem;
          hov = res_ovf;
        end
      end else if (res_valid && prev_rv) begin
        check("res_hold", {res_quo, res_rem, res_ovf}, {hq, hr, hov});
      end
      prev_rv = res_valid;
    end
  end

  // Present one operand pair and record its expectation at acceptance.
  task automatic do_op(input logic [2*DW-1:0] dd, input logic [DW-1:0] dv);
    exp_t e;
    bit   done = 1'b0;
    @(negedge clk);
    op_valid    = 1'b1;
    op_dividend = dd;
    op_divisor  = dv;
    for (int i = 0; i < 400 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (op_ready && rst_n) begin
        e      = ref_model(dd, dv);
        e.base = cyc;
        exp_q.push_back(e);
        accepted++;
        done = 1'b1;
      end
    end
    if (!done) fail_now("accept_timeout");
    @(negedge clk);
    op_valid    = 1'b0;
    op_dividend = 2*DW'($urandom);
    op_divisor  = DW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && accepted != retired; i++) @(negedge clk);
    if (accepted != retired) fail_now("drain_timeout");
  endtask

  task automatic run(input logic [2*DW-1:0] dd, input logic [DW-1:0] dv);
    do_op(dd, dv);
    drain();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_op_ready"}, 64'(op_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_quo"}, 64'(res_quo), 64'd0);
    check({tag, "_res_rem"}, 64'(res_rem), 64'd0);
    check({tag, "_res_ovf"}, 64'(res_ovf), 64'd0);
    check({tag, "_databus"}, 64'(div_databus), 64'd0);
    check({tag, "_strobes"}, 64'({div_ldu, div_ldl, div_ldd, div_st, div_ena}), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [2*DW-1:0] dd;
    logic [DW-1:0]   dv, r;
    rst_n       = 1'b0;
    op_valid    = 1'b0;
    op_dividend = '0;
    op_divisor  = '0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    rr_mode = 1;

    run(32'd100, 16'd7);
    run(32'hFFFF_FF9C, 16'd7);
    run(32'h0010_0000, 16'd1);
    run(32'd55, 16'd0);
    run(32'hFFFF_8000, 16'h0001);
    run(32'h0000_8000, 16'h0001);
    run(32'h8000_0000, 16'hFFFF);

    // Backpressure with a competing operand presented during RESP.
    rr_mode = 2;
    do_op(32'd100, 16'd7);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    if (!res_valid) fail_now("bp_result_timeout");
    fork
      do_op(32'd200, 16'd9);
      begin
        repeat (5) @(negedge clk);
        @(posedge clk);
        rr_mode = 1;
      end
    join
    drain();

    // Asynchronous reset in the tenth WAIT cycle.
    do_op(32'd100, 16'd7);
    repeat (13) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    exp_q.delete();
    slog.delete();
    retired = accepted;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_op_ready", 64'(op_ready), 64'd1);
    run(32'd100, 16'd7);

    rr_mode = 0;
    for (int n = 0; n < 50; n++) begin
      r = DW'($urandom);
      case ($urandom_range(0, 2))
        0:       dd = {{DW{r[DW-1]}}, r};
        1:       dd = 2*DW'($urandom);
        default: dd = {{DW{1'b0}}, r};
      endcase
      dv = DW'($urandom);
      if ($urandom_range(0, 7) == 0)      dv = '0;
      else if ($urandom_range(0, 3) == 0) dv = DW'($urandom_range(1, 9));
      do_op(dd, dv);
    end
    drain();
    rr_mode = 1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
